// File: rtl/pattern_det_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pattern_det_pkg
// Description : Shared types and constants for the serial pattern detector.
// Revision    : 1.0 - initial release
// ============================================================================
package pattern_det_pkg;

    localparam int MAX_LEN = 8;
    localparam int CNT_W   = 8;

    localparam logic [3:0] c_RST_PATTERN = 4'b1101;
    localparam logic [3:0] c_RST_LEN     = 4'd4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic len_legal(input logic [3:0] len, input int max_len);
        return (len != 4'd0) && (int'(len) <= max_len);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pattern_matcher.sv
`default_nettype none
// ============================================================================
// Module      : pattern_matcher
// Description : Bit history, received-bit count and masked pattern compare.
// Revision    : 1.0 - initial release
// ============================================================================
module pattern_matcher #(
    parameter int MAX_LEN = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_clr,
    input  logic               i_shift,
    input  logic               i_bit,
    input  logic [MAX_LEN-1:0] i_pattern,
    input  logic [3:0]         i_len,
    input  logic               i_overlap,
    output logic               o_hit
);
    import pattern_det_pkg::*;

    localparam int RCV_W = $clog2(MAX_LEN + 1);

    logic [MAX_LEN-1:0] r_hist;
    logic [MAX_LEN-1:0] w_hist_nxt;
    logic [MAX_LEN-1:0] w_mask;
    logic [RCV_W-1:0]   r_rcv;
    logic [RCV_W-1:0]   w_rcv_nxt;

    // The received count only has to reach the longest legal length, so it saturates there.
    always_comb begin
        w_hist_nxt = {r_hist[MAX_LEN-2:0], i_bit};
        w_rcv_nxt  = (r_rcv == RCV_W'(MAX_LEN)) ? r_rcv : r_rcv + RCV_W'(1);
        for (int k = 0; k < MAX_LEN; k++) begin
            w_mask[k] = (k < int'(i_len));
        end
        o_hit = i_shift
             && (((w_hist_nxt ^ i_pattern) & w_mask) == '0)
             && (int'(w_rcv_nxt) >= int'(i_len));
    end

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_hist <= '0;
            r_rcv  <= '0;
        end else if (i_shift) begin
            if (o_hit && !i_overlap) begin
                r_hist <= '0;
                r_rcv  <= '0;
            end else begin
                r_hist <= w_hist_nxt;
                r_rcv  <= w_rcv_nxt;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/pattern_det_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pattern_det_ctrl
// Description : Run-controlled serial pattern detector with windowed scan.
// Revision    : 1.0 - initial release
// ============================================================================
module pattern_det_ctrl #(
    parameter int MAX_LEN = pattern_det_pkg::MAX_LEN,
    parameter int CNT_W   = pattern_det_pkg::CNT_W
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic               cfg_wr,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [3:0]         cfg_len,
    input  logic               cfg_overlap,
    input  logic [CNT_W-1:0]   cfg_window,
    input  logic               start,
    input  logic               stop,
    input  logic               i,
    input  logic               i_valid,
    output logic               o,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               busy,
    output logic               done,
    output logic               cfg_err
);
    import pattern_det_pkg::*;

    state_t             r_state;
    logic [MAX_LEN-1:0] r_pattern;
    logic [3:0]         r_len;
    logic               r_overlap;
    logic [CNT_W-1:0]   r_window;
    logic [CNT_W-1:0]   r_bit_cnt;
    logic [CNT_W-1:0]   r_match_cnt;
    logic               r_cfg_err;
    logic               r_o;
    logic               r_busy;
    logic               r_done;

    logic               w_start_ok;
    logic               w_shift;
    logic               w_hit;
    logic [CNT_W-1:0]   w_bit_cnt_nxt;
    logic               w_win_end;

    // stop has priority over a coincident valid bit, so the bit never reaches the matcher.
    assign w_start_ok    = (r_state == ST_IDLE) && start && !r_cfg_err;
    assign w_shift       = (r_state == ST_RUN) && i_valid && !stop;
    assign w_bit_cnt_nxt = r_bit_cnt + CNT_W'(1);
    assign w_win_end     = w_shift && (r_window != '0) && (w_bit_cnt_nxt == r_window);

    pattern_matcher #(
        .MAX_LEN (MAX_LEN)
    ) u_matcher (
        .clk       (clk),
        .rst       (n_rst),
        .i_clr     (w_start_ok),
        .i_shift   (w_shift),
        .i_bit     (i),
        .i_pattern (r_pattern),
        .i_len     (r_len),
        .i_overlap (r_overlap),
        .o_hit     (w_hit)
    );

    always_ff @(posedge clk) begin
        if (n_rst) begin
            r_state     <= ST_IDLE;
            r_pattern   <= MAX_LEN'(c_RST_PATTERN);
            r_len       <= c_RST_LEN;
            r_overlap   <= 1'b1;
            r_window    <= '0;
            r_bit_cnt   <= '0;
            r_match_cnt <= '0;
            r_cfg_err   <= 1'b0;
            r_o         <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_o    <= w_hit;
            r_done <= 1'b0;

            if (cfg_wr && (r_state != ST_RUN)) begin
                r_pattern <= cfg_pattern;
                r_len     <= cfg_len;
                r_overlap <= cfg_overlap;
                r_window  <= cfg_window;
                r_cfg_err <= !len_legal(cfg_len, MAX_LEN);
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_start_ok) begin
                        r_state     <= ST_RUN;
                        r_busy      <= 1'b1;
                        r_match_cnt <= '0;
                        r_bit_cnt   <= '0;
                    end
                end
                ST_RUN: begin
                    if (w_shift) begin
                        r_bit_cnt <= w_bit_cnt_nxt;
                        if (w_hit && (r_match_cnt != '1)) begin
                            r_match_cnt <= r_match_cnt + CNT_W'(1);
                        end
                    end
                    if (stop || w_win_end) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o         = r_o;
    assign match_cnt = r_match_cnt;
    assign busy      = r_busy;
    assign done      = r_done;
    assign cfg_err   = r_cfg_err;

endmodule
`default_nettype wire
